// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: req/ack transaction, pipeline stall,
// load alignment/extension, store lane replication and timeout/alignment faults.
module mem_access_unit #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_memread,
    input  logic        mem_memwrite,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] mem_alu_out,
    input  logic [31:0] mem_write_data,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic [31:0] memory_read,
    output logic        mem_stall,
    output logic        mem_fault
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        access;
    logic        illegal;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] load_data;
    logic [7:0]  lb;
    logic [15:0] lh;

    assign access = mem_memread | mem_memwrite;
    assign mem_stall = (state == BUSY) | ((state == IDLE) & access);

    always_comb begin
        illegal = 1'b0;
        if (mem_memread & mem_memwrite)
            illegal = 1'b1;
        unique case (mem_size)
            2'b00: ;
            2'b01: if (mem_alu_out[0]) illegal = 1'b1;
            2'b10: if (|mem_alu_out[1:0]) illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    // Loads always fetch the whole word; byte enables only narrow stores.
    always_comb begin
        be_n    = 4'b1111;
        wdata_n = 32'h0;
        if (mem_memwrite) begin
            unique case (mem_size)
                2'b00: begin
                    be_n    = 4'b0001 << mem_alu_out[1:0];
                    wdata_n = {4{mem_write_data[7:0]}};
                end
                2'b01: begin
                    be_n    = mem_alu_out[1] ? 4'b1100 : 4'b0011;
                    wdata_n = {2{mem_write_data[15:0]}};
                end
                default: begin
                    be_n    = 4'b1111;
                    wdata_n = mem_write_data;
                end
            endcase
        end
    end

    always_comb begin
        lb        = dm_rdata[{off_q, 3'b000} +: 8];
        lh        = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        load_data = dm_rdata;
        if (dm_we)
            load_data = 32'h0;
        else if (size_q == 2'b00)
            load_data = {{24{~uns_q & lb[7]}}, lb};
        else if (size_q == 2'b01)
            load_data = {{16{~uns_q & lh[15]}}, lh};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            dm_addr     <= 32'h0;
            dm_wdata    <= 32'h0;
            dm_be       <= 4'h0;
            memory_read <= 32'h0;
            mem_fault   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (access && illegal) begin
                        mem_fault   <= 1'b1;
                        memory_read <= 32'h0;
                        state       <= DONE;
                    end else if (access) begin
                        dm_req   <= 1'b1;
                        dm_we    <= mem_memwrite;
                        dm_addr  <= {mem_alu_out[31:2], 2'b00};
                        dm_be    <= be_n;
                        dm_wdata <= wdata_n;
                        off_q    <= mem_alu_out[1:0];
                        size_q   <= mem_size;
                        uns_q    <= mem_unsigned;
                        cnt      <= 8'd0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (dm_ack) begin
                        dm_req      <= 1'b0;
                        memory_read <= load_data;
                        mem_fault   <= 1'b0;
                        state       <= DONE;
                    end else if (cnt == 8'(MAX_WAIT - 1)) begin
                        // cnt counts completed BUSY cycles before this one
                        dm_req      <= 1'b0;
                        memory_read <= 32'h0;
                        mem_fault   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
